// File: rtl/sdc_rd_pkg.sv
// -----------------------------------------------------------------------------
// sdc_rd_pkg
// Shared definitions for the SD card multi-block read path:
//   - sdc_rd_state_t : read FSM state encoding
//   - CRC16_POLY     : CRC16 polynomial x^16+x^12+x^5+1 (16'h1021)
//   - LANES          : number of SD data lines (4)
//   - CRC_LEN        : CRC length in bits per lane (16)
//   - lane_mask()    : active-lane mask for the selected bus width
// -----------------------------------------------------------------------------
package sdc_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_RD_DAT     = 3'd2,
        ST_RD_CRC     = 3'd3,
        ST_END_BIT    = 3'd4
    } sdc_rd_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam int          LANES      = 4;
    localparam int          CRC_LEN    = 16;

    // 4-bit mode uses DAT[3:0]; 1-bit mode uses DAT0 only.
    function automatic logic [LANES-1:0] lane_mask(input logic four_bit);
        return four_bit ? {LANES{1'b1}} : {{(LANES-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/sdc_crc16_lane.sv
// -----------------------------------------------------------------------------
// sdc_crc16_lane
// Serial CRC16 (x^16+x^12+x^5+1, initial value 0) over one SD data lane.
// Ports:
//   clk    : clock (rising edge)
//   srst   : synchronous active-high reset
//   i_clr  : clear the CRC register to 0 (start of block)
//   i_en   : advance the CRC with i_bit this cycle
//   i_bit  : serial data bit, MSB first
//   o_crc  : current CRC value
// -----------------------------------------------------------------------------
module sdc_crc16_lane
    import sdc_rd_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic               i_bit,
    output logic [CRC_LEN-1:0] o_crc
);

    logic [CRC_LEN-1:0] r_crc;
    logic               w_fb;

    assign w_fb = i_bit ^ r_crc[CRC_LEN-1];

    always_ff @(posedge clk) begin
        if (srst) begin
            r_crc <= '0;
        end else if (i_clr) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= {r_crc[CRC_LEN-2:0], 1'b0} ^ (w_fb ? CRC16_POLY : {CRC_LEN{1'b0}});
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sdc_multi_blk_rd.sv
// -----------------------------------------------------------------------------
// sdc_multi_blk_rd
// SD card multi-block data read engine (1-bit or 4-bit bus). Waits for the
// start bit, shifts in BLK_BYTES of data as WORD_W-bit words, captures the
// per-lane CRC16 and checks the end bit, repeating for blk_cnt blocks.
//
// Optional feature: define SDC_RD_CRC_CHECK_EN to instantiate one CRC16
// generator per lane and flag mismatches against the received CRC. Without
// it, crc_err reports end-bit errors only.
//
// Parameters: WORD_W (bits/word), BLK_BYTES (bytes/block), TO_CYC (start-bit
//             timeout in sdc_clk cycles)
// Inputs : sdc_clk, reset (sync, active high), start, blk_cnt[15:0],
//          bus_4bit, abort, dat_in[3:0]
// Outputs: dat_wrd[WORD_W-1:0], latch_wrd_strb, crc_rx[63:0] (lane n in
//          [16n+15:16n]), latch_crc_strb, crc_err (sticky per transfer),
//          tfc, timeout, busy
// -----------------------------------------------------------------------------
module sdc_multi_blk_rd
    import sdc_rd_pkg::*;
#(
    parameter int WORD_W    = 64,
    parameter int BLK_BYTES = 512,
    parameter int TO_CYC    = 65535
) (
    input  logic                     sdc_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [15:0]              blk_cnt,
    input  logic                     bus_4bit,
    input  logic                     abort,
    input  logic [3:0]               dat_in,
    output logic [WORD_W-1:0]        dat_wrd,
    output logic                     latch_wrd_strb,
    output logic [LANES*CRC_LEN-1:0] crc_rx,
    output logic                     latch_crc_strb,
    output logic                     crc_err,
    output logic                     tfc,
    output logic                     timeout,
    output logic                     busy
);

    localparam int WORDS = BLK_BYTES * 8 / WORD_W;
    localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BC_W  = $clog2(WORD_W);
    localparam int TC_W  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    localparam logic [WC_W-1:0] WC_LAST    = WC_W'(WORDS - 1);
    localparam logic [BC_W-1:0] BC_LAST_1B = BC_W'(WORD_W - 1);
    localparam logic [BC_W-1:0] BC_LAST_4B = BC_W'(WORD_W / 4 - 1);
    localparam logic [TC_W-1:0] TC_LAST    = TC_W'(TO_CYC - 1);
    localparam logic [3:0]      CC_LAST    = 4'(CRC_LEN - 1);

    sdc_rd_state_t r_state;
    sdc_rd_state_t w_state_next;

    logic [15:0]              r_blk_rem;
    logic                     r_bus_4bit;
    logic [BC_W-1:0]          r_bit_cnt;
    logic [WC_W-1:0]          r_wrd_cnt;
    logic [3:0]               r_crc_cnt;
    logic [TC_W-1:0]          r_to_cnt;
    logic [WORD_W-2:0]        r_shift;
    logic [WORD_W-1:0]        r_dat_wrd;
    logic [LANES*CRC_LEN-1:0] r_crc_rx;
    logic                     r_wrd_strb;
    logic                     r_crc_strb;
    logic                     r_crc_err;
    logic                     r_tfc;
    logic                     r_timeout;

    logic [LANES-1:0]         w_lane_mask;
    logic [LANES-1:0]         w_act;
    logic                     w_start_bit;
    logic                     w_end_bad;
    logic                     w_bit_last;
    logic                     w_blk_last_word;
    logic                     w_to_expire;
    logic                     w_crc_bad;
    logic [WORD_W-1:0]        w_word_next;
    logic [LANES*CRC_LEN-1:0] w_crc_rx_next;

    // Inactive lanes are forced to 0 so they never affect start/end detection
    // and always read back as 0 in crc_rx.
    assign w_lane_mask     = lane_mask(r_bus_4bit);
    assign w_act           = dat_in & w_lane_mask;
    assign w_start_bit     = (w_act == '0);
    assign w_end_bad       = (w_act != w_lane_mask);
    assign w_bit_last      = (r_bit_cnt == (r_bus_4bit ? BC_LAST_4B : BC_LAST_1B));
    assign w_blk_last_word = (r_wrd_cnt == WC_LAST);
    // A start bit on the expiry cycle wins over the timeout.
    assign w_to_expire     = !w_start_bit && (r_to_cnt == TC_LAST);

    // The shift register only keeps the older WORD_W-1 bits; the word is
    // completed with the bits sampled this cycle.
    assign w_word_next = r_bus_4bit ? {r_shift[WORD_W-5:0], dat_in}
                                    : {r_shift, dat_in[0]};

    for (genvar gi = 0; gi < LANES; gi++) begin : g_crc_sh
        assign w_crc_rx_next[gi*CRC_LEN +: CRC_LEN] =
            {r_crc_rx[gi*CRC_LEN +: CRC_LEN-1], w_act[gi]};
    end

`ifdef SDC_RD_CRC_CHECK_EN
    logic [LANES-1:0] w_lane_bad;
    logic             w_crc_clr;
    logic             w_crc_en;

    assign w_crc_clr = (r_state == ST_WAIT_START) && w_start_bit;
    assign w_crc_en  = (r_state == ST_RD_DAT);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_crc_chk
        logic [CRC_LEN-1:0] w_crc_calc;

        sdc_crc16_lane u_crc (
            .clk   (sdc_clk),
            .srst  (reset),
            .i_clr (w_crc_clr),
            .i_en  (w_crc_en),
            .i_bit (dat_in[gi]),
            .o_crc (w_crc_calc)
        );

        // Compared against the value crc_rx takes at the 16th CRC bit.
        assign w_lane_bad[gi] = w_lane_mask[gi] &&
                                (w_crc_calc != w_crc_rx_next[gi*CRC_LEN +: CRC_LEN]);
    end

    assign w_crc_bad = |w_lane_bad;
`else
    assign w_crc_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge sdc_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (w_start_bit)      w_state_next = ST_RD_DAT;
                else if (w_to_expire) w_state_next = ST_IDLE;
            end
            ST_RD_DAT: begin
                if (w_bit_last && w_blk_last_word) w_state_next = ST_RD_CRC;
            end
            ST_RD_CRC: begin
                if (r_crc_cnt == CC_LAST) w_state_next = ST_END_BIT;
            end
            ST_END_BIT: begin
                w_state_next = (r_blk_rem > 16'd1) ? ST_WAIT_START : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (abort) w_state_next = ST_IDLE;
    end

    // Datapath, counters and strobes
    always_ff @(posedge sdc_clk) begin
        if (reset) begin
            r_blk_rem  <= '0;
            r_bus_4bit <= 1'b0;
            r_bit_cnt  <= '0;
            r_wrd_cnt  <= '0;
            r_crc_cnt  <= '0;
            r_to_cnt   <= '0;
            r_shift    <= '0;
            r_dat_wrd  <= '0;
            r_crc_rx   <= '0;
            r_wrd_strb <= 1'b0;
            r_crc_strb <= 1'b0;
            r_crc_err  <= 1'b0;
            r_tfc      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_wrd_strb <= 1'b0;
            r_crc_strb <= 1'b0;
            r_tfc      <= 1'b0;
            r_timeout  <= 1'b0;
            if (abort) begin
                // Cancel silently: no strobes, dat_wrd/crc_rx keep last values.
                r_bit_cnt <= '0;
                r_wrd_cnt <= '0;
                r_crc_cnt <= '0;
                r_to_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_blk_rem  <= (blk_cnt == 16'd0) ? 16'd1 : blk_cnt;
                            r_bus_4bit <= bus_4bit;
                            r_crc_err  <= 1'b0;
                            r_to_cnt   <= '0;
                        end
                    end
                    ST_WAIT_START: begin
                        if (w_start_bit) begin
                            r_bit_cnt <= '0;
                            r_wrd_cnt <= '0;
                        end else if (w_to_expire) begin
                            r_timeout <= 1'b1;
                            r_to_cnt  <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    ST_RD_DAT: begin
                        r_shift <= w_word_next[WORD_W-2:0];
                        if (w_bit_last) begin
                            r_bit_cnt  <= '0;
                            r_dat_wrd  <= w_word_next;
                            r_wrd_strb <= 1'b1;
                            if (w_blk_last_word) begin
                                r_wrd_cnt <= '0;
                                r_crc_cnt <= '0;
                            end else begin
                                r_wrd_cnt <= r_wrd_cnt + 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    ST_RD_CRC: begin
                        r_crc_rx <= w_crc_rx_next;
                        if (r_crc_cnt == CC_LAST) begin
                            r_crc_cnt  <= '0;
                            r_crc_strb <= 1'b1;
                            if (w_crc_bad) r_crc_err <= 1'b1;
                        end else begin
                            r_crc_cnt <= r_crc_cnt + 1'b1;
                        end
                    end
                    ST_END_BIT: begin
                        if (w_end_bad) r_crc_err <= 1'b1;
                        if (r_blk_rem > 16'd1) begin
                            r_blk_rem <= r_blk_rem - 16'd1;
                            r_to_cnt  <= '0;
                        end else begin
                            r_tfc <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dat_wrd        = r_dat_wrd;
    assign latch_wrd_strb = r_wrd_strb;
    assign crc_rx         = r_crc_rx;
    assign latch_crc_strb = r_crc_strb;
    assign crc_err        = r_crc_err;
    assign tfc            = r_tfc;
    assign timeout        = r_timeout;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdc_multi_blk_rd.sv
// -----------------------------------------------------------------------------
// tb_sdc_multi_blk_rd
// Directed bench for sdc_multi_blk_rd (WORD_W=64, BLK_BYTES=512, TO_CYC=100).
// Inputs change and outputs are observed on the falling edge. The CRC16 sent
// after each block is generated by the bench from the data it drives.
// With SDC_RD_CRC_CHECK_EN defined, the corrupted-CRC block must raise crc_err.
// -----------------------------------------------------------------------------
module tb_sdc_multi_blk_rd;

    localparam logic [63:0] PAT = 64'h0123456789ABCDEF;
`ifdef SDC_RD_CRC_CHECK_EN
    localparam logic EXP_CRC_FLIP_ERR = 1'b1;
`else
    localparam logic EXP_CRC_FLIP_ERR = 1'b0;
`endif

    logic        sdc_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] blk_cnt;
    logic        bus_4bit;
    logic        abort;
    logic [3:0]  dat_in;
    logic [63:0] dat_wrd;
    logic        latch_wrd_strb;
    logic [63:0] crc_rx;
    logic        latch_crc_strb;
    logic        crc_err;
    logic        tfc;
    logic        timeout;
    logic        busy;

    sdc_multi_blk_rd #(
        .WORD_W    (64),
        .BLK_BYTES (512),
        .TO_CYC    (100)
    ) dut (
        .sdc_clk        (sdc_clk),
        .reset          (reset),
        .start          (start),
        .blk_cnt        (blk_cnt),
        .bus_4bit       (bus_4bit),
        .abort          (abort),
        .dat_in         (dat_in),
        .dat_wrd        (dat_wrd),
        .latch_wrd_strb (latch_wrd_strb),
        .crc_rx         (crc_rx),
        .latch_crc_strb (latch_crc_strb),
        .crc_err        (crc_err),
        .tfc            (tfc),
        .timeout        (timeout),
        .busy           (busy)
    );

    always #5 sdc_clk = ~sdc_clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          n_wstrb, n_cstrb, n_tfc, n_to;
    int          cyc = 0;
    int          to_cyc_seen;
    logic        to_busy;
    logic [63:0] exp_word;
    logic [63:0] exp_crc_rx;
    logic [63:0] cap_crc;
    logic        cap_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic clr_cnt();
        n_wstrb = 0; n_cstrb = 0; n_tfc = 0; n_to = 0;
        to_cyc_seen = -1; to_busy = 1'bx;
    endtask

    // Drive dat_in for one clock, then observe the outputs of that edge.
    task automatic step(input logic [3:0] d);
        dat_in = d;
        @(negedge sdc_clk);
        cyc++;
        if (latch_wrd_strb === 1'b1) begin
            n_wstrb++;
            chk("word_data", dat_wrd, exp_word);
        end
        if (latch_crc_strb === 1'b1) begin
            n_cstrb++;
            cap_crc = crc_rx;
            cap_err = crc_err;
        end
        if (tfc === 1'b1) n_tfc++;
        if (timeout === 1'b1) begin
            n_to++;
            to_cyc_seen = cyc;
            to_busy = busy;
        end
    endtask

    task automatic do_start(input logic four, input logic [15:0] cnt);
        blk_cnt  = cnt;
        bus_4bit = four;
        start    = 1'b1;
        step(four ? 4'hF : 4'b0001);
        start    = 1'b0;
    endtask

    // One block: idle, start bit, 64 words of w, CRC (lane 2 optionally
    // corrupted), end bit. In 1-bit mode lanes 3:1 carry junk.
    task automatic send_block(input logic four, input logic [63:0] w, input int n_wait,
                              input logic [15:0] flip2, input logic [3:0] endb);
        logic [15:0] c [4];
        logic [3:0]  nib;
        for (int n = 0; n < 4; n++) c[n] = 16'h0000;
        exp_word = w;
        repeat (n_wait) step(four ? 4'hF : 4'b0001);
        step(four ? 4'h0 : 4'b1010);
        for (int wi = 0; wi < 64; wi++) begin
            if (four) begin
                for (int i = 0; i < 16; i++) begin
                    nib = w[63-4*i -: 4];
                    step(nib);
                    for (int ln = 0; ln < 4; ln++) c[ln] = crc_upd(c[ln], nib[ln]);
                end
            end else begin
                for (int i = 0; i < 64; i++) begin
                    step({3'b010, w[63-i]});
                    c[0] = crc_upd(c[0], w[63-i]);
                end
            end
        end
        if (four) c[2] = c[2] ^ flip2;
        exp_crc_rx = four ? {c[3], c[2], c[1], c[0]} : {48'h0, c[0]};
        for (int j = 0; j < 16; j++) begin
            if (four) nib = {c[3][15-j], c[2][15-j], c[1][15-j], c[0][15-j]};
            else      nib = {3'b101, c[0][15-j]};
            step(nib);
        end
        step(endb);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] w;
        int          base;

        reset = 1'b1; start = 1'b0; abort = 1'b0; blk_cnt = 16'd0;
        bus_4bit = 1'b0; dat_in = 4'hF; exp_word = '0;
        clr_cnt();
        @(negedge sdc_clk);
        step(4'hF);
        step(4'hF);
        reset = 1'b0;
        step(4'hF);
        chk("rst_dat_wrd", dat_wrd, 64'h0);
        chk("rst_crc_rx", crc_rx, 64'h0);
        chk("rst_flags", 64'({latch_wrd_strb, latch_crc_strb, crc_err, tfc, timeout, busy}), 64'h0);

        // 1-bit single block
        clr_cnt();
        do_start(1'b0, 16'd1);
        chk("a_busy_after_start", 64'(busy), 64'd1);
        send_block(1'b0, PAT, 3, 16'h0, 4'b0001);
        step(4'b0001); step(4'b0001);
        chk("a_word_strobes", 64'(n_wstrb), 64'd64);
        chk("a_crc_strobes", 64'(n_cstrb), 64'd1);
        chk("a_tfc", 64'(n_tfc), 64'd1);
        chk("a_crc_rx", cap_crc, exp_crc_rx);
        chk("a_crc_err_at_strb", 64'(cap_err), 64'd0);
        chk("a_crc_err", 64'(crc_err), 64'd0);
        chk("a_busy_end", 64'(busy), 64'd0);

        // 4-bit, 3 blocks; a start pulse while busy must be ignored
        clr_cnt();
        do_start(1'b1, 16'd3);
        blk_cnt = 16'd1;
        start   = 1'b1;
        step(4'hF);
        start   = 1'b0;
        send_block(1'b1, PAT, 1, 16'h0, 4'hF);
        send_block(1'b1, PAT + 64'd1, 4, 16'h0, 4'hF);
        chk("b_tfc_before_last", 64'(n_tfc), 64'd0);
        send_block(1'b1, PAT + 64'd2, 4, 16'h0, 4'hF);
        step(4'hF); step(4'hF);
        chk("b_word_strobes", 64'(n_wstrb), 64'd192);
        chk("b_crc_strobes", 64'(n_cstrb), 64'd3);
        chk("b_tfc", 64'(n_tfc), 64'd1);
        chk("b_crc_rx", cap_crc, exp_crc_rx);
        chk("b_crc_err", 64'(crc_err), 64'd0);

        // 4-bit, one CRC bit flipped on lane 2
        clr_cnt();
        do_start(1'b1, 16'd1);
        send_block(1'b1, 64'hDEADBEEFCAFEF00D, 2, 16'h0100, 4'hF);
        step(4'hF);
        chk("c_crc_rx", cap_crc, exp_crc_rx);
        chk("c_crc_err_at_strb", 64'(cap_err), 64'(EXP_CRC_FLIP_ERR));
        chk("c_crc_err", 64'(crc_err), 64'(EXP_CRC_FLIP_ERR));
        chk("c_tfc", 64'(n_tfc), 64'd1);

        // blk_cnt=0 runs one block; bad end bit on lane 1
        clr_cnt();
        do_start(1'b1, 16'd0);
        send_block(1'b1, 64'h5A5A_C3C3_0FF0_9669, 2, 16'h0, 4'b1101);
        step(4'hF); step(4'hF);
        chk("e_word_strobes", 64'(n_wstrb), 64'd64);
        chk("e_crc_strobes", 64'(n_cstrb), 64'd1);
        chk("e_tfc", 64'(n_tfc), 64'd1);
        chk("e_crc_err_at_strb", 64'(cap_err), 64'd0);
        chk("e_crc_err_end", 64'(crc_err), 64'd1);

        // timeout with dat_in held high
        clr_cnt();
        do_start(1'b1, 16'd1);
        chk("t_crc_err_cleared", 64'(crc_err), 64'd0);
        base = cyc;
        for (int k = 1; k <= 105; k++) begin
            step(4'hF);
            if (k == 99) chk("t_busy_before", 64'(busy), 64'd1);
        end
        chk("t_timeout_count", 64'(n_to), 64'd1);
        chk("t_timeout_cycle", 64'(to_cyc_seen - base), 64'd100);
        chk("t_busy_at_timeout", 64'(to_busy), 64'd0);
        chk("t_tfc", 64'(n_tfc), 64'd0);

        // abort on the last nibble of word 11
        clr_cnt();
        w = PAT ^ 64'h00000000000000FF;
        exp_word = w;
        do_start(1'b1, 16'd1);
        step(4'hF);
        step(4'h0);
        for (int i = 0; i < 160; i++) step(w[63-4*(i%16) -: 4]);
        chk("x_words_before_abort", 64'(n_wstrb), 64'd10);
        w = ~w;
        for (int i = 0; i < 15; i++) step(w[63-4*i -: 4]);
        abort = 1'b1;
        step(w[3:0]);
        abort = 1'b0;
        chk("x_busy_after_abort", 64'(busy), 64'd0);
        chk("x_no_word_strobe", 64'(latch_wrd_strb), 64'd0);
        chk("x_dat_wrd_held", dat_wrd, ~w);
        repeat (20) step(4'hF);
        chk("x_words_total", 64'(n_wstrb), 64'd10);
        chk("x_no_crc_strobe", 64'(n_cstrb), 64'd0);
        chk("x_no_tfc", 64'(n_tfc), 64'd0);
        chk("x_no_timeout", 64'(n_to), 64'd0);

        // reset in the middle of word 6
        clr_cnt();
        w = PAT;
        exp_word = w;
        do_start(1'b1, 16'd2);
        step(4'hF);
        step(4'h0);
        for (int i = 0; i < 87; i++) step(w[63-4*(i%16) -: 4]);
        chk("r_words_before_reset", 64'(n_wstrb), 64'd5);
        reset = 1'b1;
        step(4'h0);
        chk("r_dat_wrd", dat_wrd, 64'h0);
        chk("r_crc_rx", crc_rx, 64'h0);
        chk("r_flags", 64'({latch_wrd_strb, latch_crc_strb, crc_err, tfc, timeout, busy}), 64'h0);
        reset = 1'b0;
        step(4'hF);
        chk("r_busy_after", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
